// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master, one-slave WISHBONE arbiter with round-robin grant and watchdog abort.
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-low reset
//   m0_*/m1_*           master side: stb/we/adr/dout in, din/ack/err out
//   s_*                 slave side: stb/we/adr/dout out, din/ack in
//   gnt                 one-hot current owner, 00 when the bus is free
module wb_bus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADR_WIDTH  = 32,
    parameter int TO_WIDTH   = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADR_WIDTH-1:0]  m0_adr,
    input  logic [DATA_WIDTH-1:0] m0_dout,
    output logic [DATA_WIDTH-1:0] m0_din,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADR_WIDTH-1:0]  m1_adr,
    input  logic [DATA_WIDTH-1:0] m1_dout,
    output logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [ADR_WIDTH-1:0]  s_adr,
    output logic [DATA_WIDTH-1:0] s_dout,
    input  logic [DATA_WIDTH-1:0] s_din,
    input  logic                  s_ack,
    output logic [1:0]            gnt
);
    typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;
    state_t state, state_nx;
    logic owner, owner_nx, last, last_nx;
    logic [TO_WIDTH-1:0] wdog, wdog_nx;
    logic busy, tout, o_stb;
    assign busy  = state == BUSY;
    assign tout  = state == TOUT;
    assign o_stb = owner ? m1_stb : m0_stb;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            wdog  <= wdog_nx;
        end
    end
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        wdog_nx  = wdog;
        if (state == IDLE) begin
            if (m0_stb | m1_stb) begin
                state_nx = BUSY;
                // on a tie the master that did not go last wins
                owner_nx = (m0_stb & m1_stb) ? ~last : m1_stb;
                wdog_nx  = '0;
            end
        end else if (busy) begin
            // an ack or an owner abort both end the cycle and pass the turn
            if (s_ack | ~o_stb) begin
                state_nx = IDLE;
                last_nx  = owner;
            end else if (wdog == TO_WIDTH'(TIMEOUT - 1)) begin
                state_nx = TOUT;
            end else begin
                wdog_nx = wdog + 1'b1;
            end
        end else begin
            state_nx = IDLE;
            last_nx  = owner;
        end
    end
    // slave side is quiet outside BUSY so a stray ack can never be forwarded
    assign s_stb  = busy & o_stb;
    assign s_we   = busy & (owner ? m1_we : m0_we);
    assign s_adr  = busy ? (owner ? m1_adr : m0_adr) : '0;
    assign s_dout = busy ? (owner ? m1_dout : m0_dout) : '0;
    assign m0_ack = s_stb & s_ack & ~owner;
    assign m1_ack = s_stb & s_ack & owner;
    assign m0_err = tout & ~owner;
    assign m1_err = tout & owner;
    assign m0_din = s_din;
    assign m1_din = s_din;
    assign gnt    = (busy | tout) ? {owner, ~owner} : 2'b00;
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
Two-master, one-slave WISHBONE arbiter (classic single-cycle stb/ack handshake) that shares the SPI master register port between two requesters, e.g. a host bridge and an autonomous config sequencer. Grants are round-robin and held until the slave acks. A watchdog terminates a stalled cycle with an error to the owning master, so the bus can never lock up.

Parameters:
DATA_WIDTH, 8, width of the data buses
ADR_WIDTH, 32, width of the address bus
TO_WIDTH, 8, width of the watchdog counter
TIMEOUT, 200, maximum BUSY cycles without ack before abort; legal range 1..2^TO_WIDTH-1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
m0_stb  in  1  master 0 cycle request
m0_we  in  1  master 0 write enable
m0_adr  in  ADR_WIDTH  master 0 address
m0_dout  in  DATA_WIDTH  master 0 write data
m0_din  out  DATA_WIDTH  read data to master 0
m0_ack  out  1  acknowledge to master 0
m0_err  out  1  timeout error to master 0
m1_*  same set as m0_*  master 1
s_stb  out  1  strobe to slave
s_we  out  1  write enable to slave
s_adr  out  ADR_WIDTH  address to slave
s_dout  out  DATA_WIDTH  write data to slave
s_din  in  DATA_WIDTH  read data from slave
s_ack  in  1  acknowledge from slave
gnt  out  2  one-hot current owner; 00 = none

Behaviour:
- FSM states: IDLE, BUSY, TOUT. Registers: state, owner (1 bit), last (1 bit), wdog (TO_WIDTH bits).
- Reset (rst=0 at a clock edge): state=IDLE, last=1 (m0 wins the first tie), wdog=0. All outputs are driven from state, so reset gives s_stb=0, s_we=0, s_adr=0, s_dout=0, all acks and errs 0, gnt=00.
- IDLE:
  - Any mX_stb=1 sampled: owner := winner, state := BUSY, wdog := 0.
  - Winner when only one requests: that master.
  - Winner when both request: the master that is not `last`.
  - The slave sees nothing during IDLE, so arbitration latency is 1 cycle.
- BUSY:
  - s_stb/s_we/s_adr/s_dout = owner's mX_stb/we/adr/dout, combinational.
  - m<owner>_ack = s_ack & s_stb, combinational.
  - gnt = one-hot(owner).
  - Non-owner ack and err are 0.
- BUSY exits:
  - s_ack=1 at edge: last := owner, state := IDLE.
  - Owner drops stb before ack (abort): state := IDLE, last := owner, no ack, no err.
  - Otherwise wdog increments. When wdog == TIMEOUT-1 with no ack, state := TOUT.
- TOUT (exactly 1 cycle):
  - s_stb=0 (the slave sees the cycle withdrawn).
  - m<owner>_err=1, gnt still shows owner.
  - Next: last := owner, state := IDLE.
- Outside BUSY: s_adr and s_dout are forced to 0, s_we to 0, s_stb to 0. A slave ack there is ignored and never forwarded.
- m0_din = m1_din = s_din always (broadcast); masters qualify it with their own ack.
- Simultaneous requests are never merged: the loser holds stb and is granted after the winner returns to IDLE. Minimum back-to-back gap is 1 IDLE cycle.
- Requests changing adr/we mid-cycle are passed through unfiltered; masters must hold them stable until ack.
- Reset during BUSY or TOUT aborts immediately: s_stb=0 at the next cycle, no ack or err emitted.
- Watchdog is saturation-free: it is cleared on every BUSY entry and only counts in BUSY.

Test Plan:
- Single write: after reset, m0 writes adr=0x04, data=0xA5; slave acks 2 cycles after seeing s_stb -> s_stb rises 1 cycle after m0_stb, s_adr=0x04, s_dout=0xA5, m0_ack pulses 1 cycle, gnt 01->00, m1_ack stays 0.
- Tie fairness: m0 and m1 both hold stb from the same cycle, slave acks on the first BUSY cycle -> grants in order m0, m1, m0, m1 over 4 transactions, each separated by exactly 1 IDLE cycle.
- Read routing: m1 reads adr=0x08, slave returns s_din=0x3C with ack -> m1_ack=1 with m1_din=0x3C, m0_ack=0.
- Timeout: TIMEOUT=4, slave never acks m0 -> BUSY for 4 cycles, then 1 TOUT cycle with s_stb=0 and m0_err=1, then IDLE; a pending m1 is granted next.
- Abort and spurious ack: m0 drops stb on the 2nd BUSY cycle -> IDLE, no ack or err; slave pulses s_ack while IDLE -> no mX_ack.
- Reset mid-cycle: rst=0 during BUSY with m1 owner -> next edge s_stb=0, gnt=00, no ack or err; after release with both requesting, m0 is granted first.
